// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST wishbone master.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        GAP     = 3'd2,
        NEXT_EL = 3'd3,
        DONE    = 3'd4
    } state_t;

    // bit1 = write, bit0 = background select ("1" background = ~BG_PATTERN)
    typedef enum logic [1:0] {
        OP_R0 = 2'b00,
        OP_R1 = 2'b01,
        OP_W0 = 2'b10,
        OP_W1 = 2'b11
    } op_t;

    typedef struct packed {
        logic       dir;
        op_t        op0;
        op_t        op1;
        logic [1:0] nops;
    } march_el_t;

    localparam int N_ELEMS = 6;

    localparam march_el_t MARCH_CM [N_ELEMS] = '{
        '{1'b0, OP_W0, OP_W0, 2'd1},
        '{1'b0, OP_R0, OP_W1, 2'd2},
        '{1'b0, OP_R1, OP_W0, 2'd2},
        '{1'b1, OP_R0, OP_W1, 2'd2},
        '{1'b1, OP_R1, OP_W0, 2'd2},
        '{1'b1, OP_R0, OP_R0, 2'd1}
    };

    function automatic march_el_t march_el(input logic [2:0] i);
        case (i)
            3'd0:    march_el = MARCH_CM[0];
            3'd1:    march_el = MARCH_CM[1];
            3'd2:    march_el = MARCH_CM[2];
            3'd3:    march_el = MARCH_CM[3];
            3'd4:    march_el = MARCH_CM[4];
            default: march_el = MARCH_CM[5];
        endcase
    endfunction

    function automatic logic [31:0] bg_word(input logic [31:0] pat, input logic bg);
        bg_word = bg ? ~pat : pat;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down word index counter with load and terminal flag for the March walker.
module sram_bist_addr_gen #(
    parameter int  WORDS = 256,
    localparam int IW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [IW-1:0] load_val,
    input  logic          step,
    input  logic          down,
    output logic [IW-1:0] idx_next,
    output logic          terminal
);

    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    logic [IW-1:0] idx_r;
    logic [IW-1:0] idx_next_s;

    // next index: load wins over step; the FSM never steps past the terminal value
    always_comb begin
        idx_next_s = idx_r;
        if (load) begin
            idx_next_s = load_val;
        end else if (step) begin
            idx_next_s = down ? (idx_r - {{(IW-1){1'b0}}, 1'b1})
                              : (idx_r + {{(IW-1){1'b0}}, 1'b1});
        end else begin
            idx_next_s = idx_r;
        end
    end

    // index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r <= {IW{1'b0}};
        end else begin
            idx_r <= idx_next_s;
        end
    end

    assign idx_next = idx_next_s;
    assign terminal = down ? (idx_r == {IW{1'b0}}) : (idx_r == LAST_IDX);

endmodule

// File: rtl/sram_bist_wb_master.sv
// Wishbone master running March C- on the SRAM slave; reports pass/fail, first bad address, error count.
// Optional build macro SRAM_BIST_TIMEOUT_EN adds an ack timeout of TIMEOUT_CYC cycles per access.
module sram_bist_wb_master
    import sram_bist_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDR_WORDS = 256,
    parameter logic [31:0] BG_PATTERN = 32'h5555_AAAA
`ifdef SRAM_BIST_TIMEOUT_EN
    , parameter int        TIMEOUT_CYC = 255
`endif
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] fail_addr_o,
    output logic [15:0] err_cnt_o
);

    localparam int            IW       = $clog2(ADDR_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(ADDR_WORDS - 1);

    state_t        state_r, state_s;
    logic [2:0]    el_r, el_s;
    logic          op_sel_r, op_sel_s;
    logic          load_s, step_s;
    logic [IW-1:0] load_val_s, idx_next_s;
    logic          terminal_s;
    march_el_t     cur_el_s, nxt_el_s;
    op_t           cur_op_s, nxt_op_s;
    logic          timeout_s, mismatch_s, start_accept_s;
    logic [31:0]   rd_data_r;

    logic          cyc_r, we_r, busy_r, done_r, pass_r;
    logic [3:0]    sel_r;
    logic [31:0]   adr_r, dat_r, fail_addr_r;
    logic [15:0]   err_cnt_r;

    sram_bist_addr_gen #(.WORDS(ADDR_WORDS)) u_addr_gen (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (load_s),
        .load_val (load_val_s),
        .step     (step_s),
        .down     (cur_el_s.dir),
        .idx_next (idx_next_s),
        .terminal (terminal_s)
    );

    // the second op of an element only exists when the element carries two ops
    assign cur_el_s       = march_el(el_r);
    assign nxt_el_s       = march_el(el_s);
    assign cur_op_s       = (op_sel_r && cur_el_s.nops == 2'd2) ? cur_el_s.op1 : cur_el_s.op0;
    assign nxt_op_s       = (op_sel_s && nxt_el_s.nops == 2'd2) ? nxt_el_s.op1 : nxt_el_s.op0;
    assign load_val_s     = nxt_el_s.dir ? LAST_IDX : {IW{1'b0}};
    assign start_accept_s = start_i && (state_r == IDLE || state_r == DONE);
    assign mismatch_s     = (state_r == GAP) && !cur_op_s[1]
                            && (rd_data_r != bg_word(BG_PATTERN, cur_op_s[0]));

`ifdef SRAM_BIST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt_r;

    // cycles spent in the current REQ without ack
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (state_r == REQ && state_s == REQ) begin
            wait_cnt_r <= wait_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= {TW{1'b0}};
        end
    end

    assign timeout_s = (state_r == REQ) && !wbm_ack_i && (wait_cnt_r == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // next-state and walker control
    always_comb begin
        state_s  = state_r;
        el_s     = el_r;
        op_sel_s = op_sel_r;
        load_s   = 1'b0;
        step_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    state_s  = REQ;
                    el_s     = 3'd0;
                    op_sel_s = 1'b0;
                    load_s   = 1'b1;
                end else begin
                    state_s  = IDLE;
                end
            end
            REQ: begin
                if (wbm_ack_i) begin
                    state_s = GAP;
                end else if (timeout_s) begin
                    state_s = DONE;
                end else begin
                    state_s = REQ;
                end
            end
            GAP: begin
                if (!op_sel_r && cur_el_s.nops == 2'd2) begin
                    op_sel_s = 1'b1;
                    state_s  = REQ;
                end else if (terminal_s) begin
                    state_s  = NEXT_EL;
                end else begin
                    op_sel_s = 1'b0;
                    step_s   = 1'b1;
                    state_s  = REQ;
                end
            end
            NEXT_EL: begin
                if (el_r == 3'(N_ELEMS - 1)) begin
                    state_s  = DONE;
                end else begin
                    el_s     = el_r + 3'd1;
                    op_sel_s = 1'b0;
                    load_s   = 1'b1;
                    state_s  = REQ;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM and walker state registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r  <= IDLE;
            el_r     <= 3'd0;
            op_sel_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            el_r     <= el_s;
            op_sel_r <= op_sel_s;
        end
    end

    // bus outputs are loaded on entry to REQ and held until the next access
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_r     <= 1'b0;
            sel_r     <= 4'h0;
            we_r      <= 1'b0;
            adr_r     <= 32'h0;
            dat_r     <= 32'h0;
            rd_data_r <= 32'h0;
        end else begin
            cyc_r <= (state_s == REQ);
            sel_r <= (state_s == REQ) ? 4'hF : 4'h0;
            if (state_s == REQ) begin
                we_r  <= nxt_op_s[1];
                adr_r <= BASE_ADDR + {{(30-IW){1'b0}}, idx_next_s, 2'b00};
                dat_r <= nxt_op_s[1] ? bg_word(BG_PATTERN, nxt_op_s[0]) : 32'h0;
            end
            if (state_r == REQ && wbm_ack_i) begin
                rd_data_r <= wbm_dat_i;
            end
        end
    end

    // test status and result registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_addr_r <= 32'h0;
            err_cnt_r   <= 16'h0;
        end else if (start_accept_s) begin
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_addr_r <= 32'h0;
            err_cnt_r   <= 16'h0;
        end else begin
            if (mismatch_s) begin
                if (err_cnt_r != 16'hFFFF) begin
                    err_cnt_r <= err_cnt_r + 16'd1;
                end
                if (err_cnt_r == 16'h0) begin
                    fail_addr_r <= adr_r;
                end
            end
            if (timeout_s) begin
                fail_addr_r <= adr_r;
            end
            if (state_s == DONE && state_r != DONE) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
                pass_r <= (err_cnt_r == 16'h0) && !timeout_s;
            end
        end
    end

    assign wbm_cyc_o   = cyc_r;
    assign wbm_stb_o   = cyc_r;
    assign wbm_we_o    = we_r;
    assign wbm_sel_o   = sel_r;
    assign wbm_adr_o   = adr_r;
    assign wbm_dat_o   = dat_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign pass_o      = pass_r;
    assign fail_addr_o = fail_addr_r;
    assign err_cnt_o   = err_cnt_r;

endmodule
